// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and default sizes for the multiplier-sharing arbiter.
// Contents: FSM state enum, default NREQ/W and derived tag width IDW.
package mult_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int IDW_DEF  = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request/response bus between requesters, consumer and the arbiter.
// master: drives req_valid/req_a/req_b/rsp_ready; slave: the arbiter.
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/barrel_multiplier.sv
// Combinational unsigned 8x8 -> 16 shift-and-add multiplier.
// Ports: i_a, i_b operands; o_p full 16-bit product.
module barrel_multiplier (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);

  always_comb begin
    o_p = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_b[i]) o_p = o_p + ({8'd0, i_a} << i);
    end
  end

endmodule

// File: rtl/mult_share_arbiter_rr.sv
// Combinational round-robin picker: first valid index after i_ptr.
// Ports: i_valid, i_ptr in; o_grant one-hot, o_winner binary, o_any.
module mult_arb_rr #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_winner,
  output logic            o_any
);

  always_comb begin
    int w_idx;
    logic [IDW-1:0] w_sel;
    w_idx    = 0;
    w_sel    = '0;
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    // Scan starts one past the last winner, ends on the last winner.
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = (int'(i_ptr) + i) % NREQ;
      w_sel = IDW'(w_idx);
      if (!o_any && i_valid[w_sel]) begin
        o_any          = 1'b1;
        o_winner       = w_sel;
        o_grant[w_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin shares one barrel_multiplier among NREQ requesters.
// Ports: clk, rst (async high), bus (slave), perf_ops if MUL_PERF_CNT_EN.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_arbiter_if.slave  bus
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_ops
`endif
);

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_op_id;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [2*W-1:0]  r_rsp_p;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_winner;
  logic            w_any;
  logic            w_grant_en;
  logic            w_take;
  logic            w_rsp_hs;
  logic [2*W-1:0]  w_prod;

  mult_arb_rr #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .i_valid  (bus.req_valid),
    .i_ptr    (r_rr_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  barrel_multiplier u_mul (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;
  assign w_take   = w_grant_en & w_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_take) w_next = MUL;
      MUL:     w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = w_take ? MUL : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grants are gated by rst so every output reads 0 while in reset.
  always_comb begin
    w_grant_en = 1'b0;
    unique case (r_state)
      IDLE:    w_grant_en = !rst;
      RESP:    w_grant_en = !rst && bus.rsp_ready;
      default: w_grant_en = 1'b0;
    endcase
    bus.req_ready = w_grant_en ? w_grant : '0;
  end

  // rsp_valid drops on every handshake; a back-to-back op
  // re-raises it from MUL, so a product is never presented twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= IDW'(NREQ - 1);
      r_op_id     <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_p     <= '0;
    end else begin
      if (w_take) begin
        r_op_a   <= bus.req_a[w_winner*W +: W];
        r_op_b   <= bus.req_b[w_winner*W +: W];
        r_op_id  <= w_winner;
        r_rr_ptr <= w_winner;
      end
      if (r_state == MUL) begin
        r_rsp_valid <= 1'b1;
        r_rsp_p     <= w_prod;
        r_rsp_id    <= r_op_id;
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_p     = r_rsp_p;

`ifdef MUL_PERF_CNT_EN
  logic [31:0] r_perf_ops;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_perf_ops <= '0;
    else if (w_rsp_hs && r_perf_ops != 32'hFFFF_FFFF)
      r_perf_ops <= r_perf_ops + 32'd1;
  end

  assign perf_ops = r_perf_ops;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter.
// Inputs change and outputs are checked on the falling clock edge.
module tb_mult_share_arbiter;
  import mult_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
`ifdef MUL_PERF_CNT_EN
  logic [31:0] perf_ops;
`endif

  mult_share_arbiter_if bus ();

  mult_share_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MUL_PERF_CNT_EN
    ,
    .perf_ops (perf_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    bus.req_valid = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 0000", bus.req_ready);
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_p !== 16'h0 || bus.rsp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_rsp: got v=%b p=%h id=%0d want 0/0/0",
               bus.rsp_valid, bus.rsp_p, bus.rsp_id);
    end
    n_cmp++;
    if (dut.r_state !== IDLE || dut.r_rr_ptr !== 2'd3) begin
      n_bad++;
      $display("FAIL rst_state: got st=%0d ptr=%0d want 0/3",
               dut.r_state, dut.r_rr_ptr);
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    bus.req_valid = 4'b0001;
    bus.req_a[7:0] = 8'd3;
    bus.req_b[7:0] = 8'd5;
    bus.rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL t1_grant: got %b want 0001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_early: got rsp_valid=%b want 0", bus.rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 16'd15 || bus.rsp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL t1_rsp: got v=%b p=%0d id=%0d want 1/15/0",
               bus.rsp_valid, bus.rsp_p, bus.rsp_id);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_drop: got rsp_valid=%b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_all_valid;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_p;
    apply_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*8 +: 8] = 8'(i + 1);
      bus.req_b[i*8 +: 8] = 8'd10;
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL t2_first: got %b want 0001", bus.req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL t2_gap%0d: got rsp_valid=%b want 0", k, bus.rsp_valid);
      end
      @(negedge clk);
      exp_p   = 16'(((k % 4) + 1) * 10);
      exp_rdy = 4'b0001 << ((k + 1) % 4);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== exp_p ||
          bus.rsp_id !== 2'(k % 4)) begin
        n_bad++;
        $display("FAIL t2_rsp%0d: got v=%b p=%0d id=%0d want 1/%0d/%0d",
                 k, bus.rsp_valid, bus.rsp_p, bus.rsp_id, exp_p, k % 4);
      end
      n_cmp++;
      if (bus.req_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL t2_rdy%0d: got %b want %b", k, bus.req_ready, exp_rdy);
      end
      if (k == 4) bus.req_valid = '0;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || dut.r_state !== IDLE) begin
      n_bad++;
      $display("FAIL t2_idle: got v=%b st=%0d want 0/0",
               bus.rsp_valid, dut.r_state);
    end
  endtask

  task automatic test_boundary;
    clear_inputs();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_a[7:0] = 8'd255;
    bus.req_b[7:0] = 8'd255;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL t3_grant: got %b want 0001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_a[7:0] = 8'd0;
    bus.req_b[7:0] = 8'd200;
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 16'hFE01) begin
      n_bad++;
      $display("FAIL t3_max: got v=%b p=%h want 1/fe01",
               bus.rsp_valid, bus.rsp_p);
    end
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL t3_b2b: got %b want 0001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 16'h0000 || bus.rsp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL t3_zero: got v=%b p=%h id=%0d want 1/0000/0",
               bus.rsp_valid, bus.rsp_p, bus.rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    clear_inputs();
    bus.req_valid = 4'b0011;
    bus.req_a[7:0]  = 8'd2;
    bus.req_b[7:0]  = 8'd3;
    bus.req_a[15:8] = 8'd4;
    bus.req_b[15:8] = 8'd5;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL t4_grant: got %b want 0010", bus.req_ready);
    end
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 16'd20 ||
          bus.rsp_id !== 2'd1 || bus.req_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL t4_hold%0d: got v=%b p=%0d id=%0d rdy=%b want 1/20/1/0000",
                 k, bus.rsp_valid, bus.rsp_p, bus.rsp_id, bus.req_ready);
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001 || bus.rsp_p !== 16'd20) begin
      n_bad++;
      $display("FAIL t4_release: got rdy=%b p=%0d want 0001/20",
               bus.req_ready, bus.rsp_p);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 16'd6 || bus.rsp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL t4_next: got v=%b p=%0d id=%0d want 1/6/0",
               bus.rsp_valid, bus.rsp_p, bus.rsp_id);
    end
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_end: got rsp_valid=%b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_a[23:16] = 8'd9;
    bus.req_b[23:16] = 8'd9;
    @(negedge clk);
    n_cmp++;
    if (dut.r_state !== MUL) begin
      n_bad++;
      $display("FAIL t5_inmul: got st=%0d want 1", dut.r_state);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || dut.r_state !== IDLE ||
        dut.r_rr_ptr !== 2'd3 || dut.r_op_a !== 8'd0) begin
      n_bad++;
      $display("FAIL t5_rst: got v=%b st=%0d ptr=%0d opa=%0d want 0/0/3/0",
               bus.rsp_valid, dut.r_state, dut.r_rr_ptr, dut.r_op_a);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    bus.req_a[15:8] = 8'd7;
    bus.req_b[15:8] = 8'd6;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL t5_lowest: got %b want 0010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 16'd42 || bus.rsp_id !== 2'd1) begin
      n_bad++;
      $display("FAIL t5_rsp: got v=%b p=%0d id=%0d want 1/42/1",
               bus.rsp_valid, bus.rsp_p, bus.rsp_id);
    end
    @(negedge clk);
  endtask

`ifdef MUL_PERF_CNT_EN
  task automatic one_op(input logic [7:0] a);
    bus.req_valid = 4'b0001;
    bus.req_a[7:0] = a;
    bus.req_b[7:0] = 8'd1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_perf;
    apply_reset();
    n_cmp++;
    if (perf_ops !== 32'd0) begin
      n_bad++;
      $display("FAIL t6_init: got %0d want 0", perf_ops);
    end
    for (int k = 0; k < 7; k++) one_op(8'(k));
    n_cmp++;
    if (perf_ops !== 32'd7) begin
      n_bad++;
      $display("FAIL t6_count: got %0d want 7", perf_ops);
    end
    force dut.r_perf_ops = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_perf_ops;
    one_op(8'd1);
    n_cmp++;
    if (perf_ops !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL t6_sat: got %h want ffffffff", perf_ops);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_all_valid();
    test_boundary();
    test_stall();
    test_reset_mid();
`ifdef MUL_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
